// File: rtl/ispy_playback_pkg.sv
// Shared types and constants for the input-side playback buffer.
package ispy_playback_pkg;

    localparam int unsigned IspyDataW = 30;
    localparam int unsigned IspyAddrW = 10;
    localparam int unsigned CntW      = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPrime = 2'd1,
        StPlay  = 2'd2,
        StDone  = 2'd3
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
        return (&v) ? v : v + CntW'(1);
    endfunction

endpackage

// File: rtl/ispy_ram.sv
// Dual-port pattern RAM: port A read/write (VME), port B read-only (playback).
// Both reads are synchronous with one cycle of latency; output registers reset to 0.
module ispy_ram #(
    parameter int unsigned DATA_W = 30,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_en,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_rdata
);

    localparam int unsigned Depth = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [Depth];

    // Storage array: written only through port A, never reset.
    always_ff @(posedge clk) begin
        if (a_en && a_we) begin
            mem[a_addr] <= a_wdata;
        end
    end

    // Port A read register (read-before-write on a colliding write).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdata <= '0;
        end else if (a_en) begin
            a_rdata <= mem[a_addr];
        end
    end

    // Port B read register; holds its value while b_en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_rdata <= '0;
        end else if (b_en) begin
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/ispy_playback.sv
// Input-side playback buffer: VME loads a pattern while frozen, then the FSM
// streams it out with a valid/hold handshake, once or looping.
module ispy_playback
    import ispy_playback_pkg::*;
#(
    parameter int unsigned DATA_W = IspyDataW,
    parameter int unsigned ADDR_W = IspyAddrW
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W+1:2] VMEaddr,
    input  logic              ispy_addr_sel,
    input  logic              vme_we,
    input  logic [DATA_W-1:0] vme_data_in,
    output logic [DATA_W-1:0] vme_data_out,
    input  logic              freeze,
    input  logic              start,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic              hold,
    output logic [DATA_W-1:0] data_out,
    output logic              push_out,
    output logic              busy,
    output logic              done,
    output logic [CntW-1:0]   word_cnt,
    output logic [ADDR_W-1:0] ispy_addr
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic              loop_q, loop_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              vme_sel;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              transfer;

    assign vme_sel  = freeze && ispy_addr_sel;
    assign push_out = (state_q == StPlay);
    assign busy     = (state_q == StPrime) || (state_q == StPlay);
    assign done     = (state_q == StDone);
    assign transfer = push_out && !hold;
    assign word_cnt = cnt_q;
    // The RAM register holds the presented word while no new read is issued,
    // which keeps data_out stable under hold.
    assign data_out = push_out ? rd_data : '0;
    assign ispy_addr = vme_sel ? VMEaddr : cur_addr_q;

    ispy_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (reset_n),
        .a_en    (vme_sel),
        .a_we    (vme_we),
        .a_addr  (VMEaddr),
        .a_wdata (vme_data_in),
        .a_rdata (vme_data_out),
        .b_en    (rd_en),
        .b_addr  (rd_addr),
        .b_rdata (rd_data)
    );

    // State, address, latched config and word counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cur_addr_q  <= '0;
            last_addr_q <= '0;
            loop_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            last_addr_q <= last_addr_d;
            loop_q      <= loop_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state logic and playback read issue.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        last_addr_d = last_addr_q;
        loop_d      = loop_q;
        cnt_d       = cnt_q;
        rd_en       = 1'b0;
        rd_addr     = cur_addr_q;

        // Counts also in an abort cycle, as long as the word was accepted.
        if (transfer) begin
            cnt_d = sat_inc(cnt_q);
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (freeze) begin
                    state_d = StIdle;
                end else if (start) begin
                    state_d     = StPrime;
                    last_addr_d = last_addr;
                    loop_d      = loop_en;
                    cnt_d       = '0;
                end
            end
            StPrime: begin
                if (freeze) begin
                    state_d = StIdle;
                end else begin
                    rd_en      = 1'b1;
                    rd_addr    = '0;
                    cur_addr_d = '0;
                    state_d    = StPlay;
                end
            end
            StPlay: begin
                if (freeze) begin
                    state_d = StIdle;
                end else if (transfer) begin
                    if (cur_addr_q != last_addr_q) begin
                        rd_en      = 1'b1;
                        rd_addr    = cur_addr_q + ADDR_W'(1);
                        cur_addr_d = cur_addr_q + ADDR_W'(1);
                    end else if (loop_q) begin
                        rd_en      = 1'b1;
                        rd_addr    = '0;
                        cur_addr_d = '0;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_ispy_playback.sv
// Directed bench for ispy_playback with hand-computed expectations.
module tb_ispy_playback;

    logic        clk;
    logic        reset_n;
    logic [11:2] VMEaddr;
    logic        ispy_addr_sel;
    logic        vme_we;
    logic [29:0] vme_data_in;
    logic [29:0] vme_data_out;
    logic        freeze;
    logic        start;
    logic        loop_en;
    logic [9:0]  last_addr;
    logic        hold;
    logic [29:0] data_out;
    logic        push_out;
    logic        busy;
    logic        done;
    logic [15:0] word_cnt;
    logic [9:0]  ispy_addr;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [29:0] PatA = 30'h2AAA_AAAA;
    localparam logic [29:0] PatB = 30'h1555_5555;
    localparam logic [29:0] PatTop = 30'h3FFF_FFFF;

    ispy_playback u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .VMEaddr       (VMEaddr),
        .ispy_addr_sel (ispy_addr_sel),
        .vme_we        (vme_we),
        .vme_data_in   (vme_data_in),
        .vme_data_out  (vme_data_out),
        .freeze        (freeze),
        .start         (start),
        .loop_en       (loop_en),
        .last_addr     (last_addr),
        .hold          (hold),
        .data_out      (data_out),
        .push_out      (push_out),
        .busy          (busy),
        .done          (done),
        .word_cnt      (word_cnt),
        .ispy_addr     (ispy_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vme_write(input logic [9:0] addr, input logic [29:0] data);
        freeze        = 1'b1;
        ispy_addr_sel = 1'b1;
        vme_we        = 1'b1;
        VMEaddr       = addr;
        vme_data_in   = data;
        tick();
        vme_we        = 1'b0;
        ispy_addr_sel = 1'b0;
    endtask

    task automatic vme_read(input string tag, input logic [9:0] addr, input logic [29:0] exp);
        freeze        = 1'b1;
        ispy_addr_sel = 1'b1;
        VMEaddr       = addr;
        tick();
        check(tag, {2'b0, vme_data_out}, {2'b0, exp});
        ispy_addr_sel = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int gaps;
        reset_n       = 1'b0;
        VMEaddr       = '0;
        ispy_addr_sel = 1'b0;
        vme_we        = 1'b0;
        vme_data_in   = '0;
        freeze        = 1'b0;
        start         = 1'b0;
        loop_en       = 1'b0;
        last_addr     = '0;
        hold          = 1'b0;
        #1;
        check("rst_push", {31'b0, push_out}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_cnt", {16'b0, word_cnt}, 0);
        check("rst_data", {2'b0, data_out}, 0);
        check("rst_vme", {2'b0, vme_data_out}, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Single pass, no backpressure
        for (int i = 0; i < 4; i++) vme_write(10'(i), 30'(i + 1));
        freeze    = 1'b0;
        last_addr = 10'd3;
        loop_en   = 1'b0;
        hold      = 1'b0;
        pulse_start();
        check("prime_busy", {31'b0, busy}, 1);
        check("prime_push", {31'b0, push_out}, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("p1_push%0d", i), {31'b0, push_out}, 1);
            check($sformatf("p1_data%0d", i), {2'b0, data_out}, 32'(i + 1));
        end
        tick();
        check("p1_done", {31'b0, done}, 1);
        check("p1_push_off", {31'b0, push_out}, 0);
        check("p1_busy_off", {31'b0, busy}, 0);
        check("p1_cnt", {16'b0, word_cnt}, 4);
        tick();
        check("p1_done_hold", {31'b0, done}, 1);

        // Single pass with hold during T+3..T+5
        pulse_start();
        check("p2_done_clr", {31'b0, done}, 0);
        check("p2_cnt_clr", {16'b0, word_cnt}, 0);
        tick();
        check("p2_d_t2", {2'b0, data_out}, 1);
        tick();
        hold = 1'b1;
        check("p2_d_t3", {2'b0, data_out}, 2);
        tick();
        check("p2_d_t4", {2'b0, data_out}, 2);
        tick();
        check("p2_d_t5", {2'b0, data_out}, 2);
        tick();
        hold = 1'b0;
        check("p2_d_t6", {2'b0, data_out}, 2);
        tick();
        check("p2_d_t7", {2'b0, data_out}, 3);
        tick();
        check("p2_d_t8", {2'b0, data_out}, 4);
        check("p2_push_t8", {31'b0, push_out}, 1);
        tick();
        check("p2_done", {31'b0, done}, 1);
        check("p2_cnt", {16'b0, word_cnt}, 4);

        // Looping two-word pattern; config changes mid-play must not matter
        vme_write(10'd0, PatA);
        vme_write(10'd1, PatB);
        freeze    = 1'b0;
        last_addr = 10'd1;
        loop_en   = 1'b1;
        pulse_start();
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 2) begin
                loop_en   = 1'b0;
                last_addr = 10'd3;
            end
            check($sformatf("lp_push%0d", k), {31'b0, push_out}, 1);
            check($sformatf("lp_data%0d", k), {2'b0, data_out},
                  {2'b0, (k % 2 == 1) ? PatA : PatB});
            check($sformatf("lp_done%0d", k), {31'b0, done}, 0);
        end
        check("lp_busy", {31'b0, busy}, 1);
        check("lp_cnt", {16'b0, word_cnt}, 5);
        tick();
        check("lp_data7", {2'b0, data_out}, {2'b0, PatA});
        freeze = 1'b1;
        tick();
        check("abort_push", {31'b0, push_out}, 0);
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_done", {31'b0, done}, 0);
        check("abort_cnt", {16'b0, word_cnt}, 7);
        vme_read("rb_addr2", 10'd2, 30'h3);
        vme_read("rb_addr0", 10'd0, PatA);

        // Asynchronous reset in the middle of play
        vme_write(10'd0, 30'h1);
        vme_write(10'd1, 30'h2);
        freeze    = 1'b0;
        last_addr = 10'd3;
        loop_en   = 1'b1;
        pulse_start();
        tick();
        tick();
        check("pre_rst_data", {2'b0, data_out}, 2);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_push", {31'b0, push_out}, 0);
        check("arst_busy", {31'b0, busy}, 0);
        check("arst_data", {2'b0, data_out}, 0);
        check("arst_cnt", {16'b0, word_cnt}, 0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("post_rst_push", {31'b0, push_out}, 0);
        vme_read("post_rst_rb1", 10'd1, 30'h2);
        vme_read("post_rst_rb3", 10'd3, 30'h4);

        // Unfrozen VME write is dropped; start while frozen is ignored
        freeze        = 1'b0;
        ispy_addr_sel = 1'b1;
        vme_we        = 1'b1;
        VMEaddr       = 10'd0;
        vme_data_in   = 30'h3FF;
        tick();
        vme_we        = 1'b0;
        ispy_addr_sel = 1'b0;
        vme_read("nofrz_wr", 10'd0, 30'h1);
        freeze = 1'b1;
        pulse_start();
        tick();
        check("frz_start_push", {31'b0, push_out}, 0);
        check("frz_start_busy", {31'b0, busy}, 0);

        // Single-word loop
        freeze    = 1'b0;
        last_addr = 10'd0;
        loop_en   = 1'b1;
        pulse_start();
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("one_push%0d", k), {31'b0, push_out}, 1);
            check($sformatf("one_data%0d", k), {2'b0, data_out}, 1);
        end
        check("one_cnt", {16'b0, word_cnt}, 2);
        freeze = 1'b1;
        tick();
        check("one_abort", {31'b0, busy}, 0);

        // Full-depth loop wraps 1023 -> 0 without a bubble
        vme_write(10'd1023, PatTop);
        freeze    = 1'b0;
        last_addr = 10'd1023;
        loop_en   = 1'b1;
        pulse_start();
        gaps = 0;
        for (int k = 1; k <= 1025; k++) begin
            tick();
            if (!push_out) gaps++;
            if (k == 1024) begin
                check("wrap_top_data", {2'b0, data_out}, {2'b0, PatTop});
                check("wrap_top_addr", {22'b0, ispy_addr}, 1023);
            end
            if (k == 1025) begin
                check("wrap_zero_data", {2'b0, data_out}, 1);
                check("wrap_cnt", {16'b0, word_cnt}, 1024);
            end
        end
        check("wrap_gaps", gaps, 0);
        freeze = 1'b1;
        tick();
        check("wrap_abort", {31'b0, push_out}, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
